fifo_burst_reader: RTL and testbench

Read-side controller for the 8-deep synchronous FIFO. On a start pulse it pulls a programmed number of words through the FIFO's `re`/`e`/`dout` read port, absorbing the FIFO's one-cycle read latency. It re-presents the words on a valid/ready stream through a 2-entry output buffer, flags the final word of the burst, and pulses `done` when the burst has fully drained.

---
 rtl/fifo_burst_reader.sv | 167 ++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Read-side controller for an 8-deep synchronous FIFO. A start pulse, accepted
// only while idle, latches a burst length (0 encodes 256). The block then pulls
// that many words out of the FIFO read port. The FIFO returns data one edge
// after a read is sampled, so each accepted read is tracked as "in flight" for
// one cycle and captured on the following edge into a 2-entry output buffer.
// The buffer is presented downstream as a valid/ready stream. The final word
// of the burst carries m_last. done pulses once that word has been accepted.
//
// Ports
//   clk        in   single clock, all state changes on its rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle burst request (ignored while busy)
//   len        in   burst length sampled with start, 0 means 256 words
//   fifo_e     in   FIFO empty flag
//   fifo_dout  in   FIFO read data, valid the cycle after a sampled read
//   fifo_re    out  FIFO read enable (combinational)
//   m_valid    out  output word valid
//   m_data     out  output word (buffer head)
//   m_last     out  final word of the burst, qualified by m_valid
//   m_ready    in   downstream accept
//   busy       out  burst in progress
//   done       out  one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    len,
  input  logic          fifo_e,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_re,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_r;
  logic [8:0]    remaining_r;   // reads still to be issued
  logic [8:0]    burst_len_r;   // effective burst length, 1..256
  logic [8:0]    delivered_r;   // words already popped downstream
  logic          inflight_r;    // a read was sampled last edge; data arrives now
  logic [1:0]    occ_r;         // output buffer occupancy, 0..2
  logic [DW-1:0] buf0_r;        // buffer head
  logic [DW-1:0] buf1_r;        // buffer second entry
  logic          last_r;        // head is the final word of the burst
  logic          done_r;

  logic          pop_s;
  logic [2:0]    fill_s;
  logic          fifo_re_s;
  logic [1:0]    push_idx_s;

  // Read issue and buffer accounting.
  // fill_s is the buffer demand after this edge if no new read were issued:
  // words held plus the word in flight, minus the word leaving. Issuing a new
  // read only while this is below 2 guarantees that the in-flight word always
  // has a free slot when it lands, so the buffer can never overflow.
  always_comb begin
    pop_s      = (occ_r != 2'd0) && m_ready;
    fill_s     = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    fifo_re_s  = (state_r == READ) && !fifo_e &&
                 (remaining_r != 9'd0) && (fill_s < 3'd2);
    // Landing slot for the captured word, after any same-edge pop shifts
    // the second entry into the head.
    if (pop_s) begin
      push_idx_s = occ_r - 2'd1;
    end else begin
      push_idx_s = occ_r;
    end
  end

  // Control FSM, read tracking, output buffer and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      remaining_r <= 9'd0;
      burst_len_r <= 9'd0;
      delivered_r <= 9'd0;
      inflight_r  <= 1'b0;
      occ_r       <= 2'd0;
      buf0_r      <= {DW{1'b0}};
      buf1_r      <= {DW{1'b0}};
      last_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      inflight_r <= fifo_re_s;
      occ_r      <= occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
      done_r     <= pop_s && last_r;

      // Head advances on a pop; a captured word then lands behind whatever
      // remains, which may be the head itself.
      if (pop_s) begin
        buf0_r <= buf1_r;
      end
      if (inflight_r) begin
        if (push_idx_s == 2'd0) begin
          buf0_r <= fifo_dout;
        end else begin
          buf1_r <= fifo_dout;
        end
      end

      // m_last tracks whether the next word to leave is the final one, so it
      // is computed ahead from the count after this pop.
      if (pop_s) begin
        delivered_r <= delivered_r + 9'd1;
        if (last_r) begin
          last_r <= 1'b0;
        end else begin
          last_r <= ((delivered_r + 9'd1) == (burst_len_r - 9'd1));
        end
      end

      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= READ;
            remaining_r <= (len == 8'd0) ? 9'd256 : {1'b0, len};
            burst_len_r <= (len == 8'd0) ? 9'd256 : {1'b0, len};
            delivered_r <= 9'd0;
            last_r      <= (len == 8'd1);
          end
        end
        READ: begin
          if (fifo_re_s) begin
            remaining_r <= remaining_r - 9'd1;
            if (remaining_r == 9'd1) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Once every read is issued, the final pop is the only way the
          // buffer and in-flight slot can become empty together.
          if (pop_s && last_r) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign fifo_re = fifo_re_s;
  assign m_valid = (occ_r != 2'd0);
  assign m_data  = buf0_r;
  assign m_last  = last_r;
  assign busy    = (state_r != IDLE);
  assign done    = done_r;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// Testbench for fifo_burst_reader. A queue-based FIFO model with a producer
// feeds the DUT. A transaction-level reference model tracks burst acceptance,
// word order, the last-word flag, busy and done.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    len = 8'd0;
  logic          fifo_e;
  logic [DW-1:0] fifo_dout;
  logic          fifo_re;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .fifo_e    (fifo_e),
    .fifo_dout (fifo_dout),
    .fifo_re   (fifo_re),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- FIFO + producer model ----------------
  logic [7:0] fq[$];      // FIFO contents
  logic [7:0] pend_q[$];  // words waiting to be written
  logic [7:0] exp_q[$];   // every word written, in order: expected output
  logic [7:0] fw;
  bit         prod_rand = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      pend_q.delete();
      exp_q.delete();
      fifo_e    <= 1'b1;
      fifo_dout <= 8'h00;
    end else begin
      if (fifo_re && !fifo_e && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (pend_q.size() > 0 && fq.size() < 8 && (!prod_rand || $urandom_range(0, 1) == 1)) begin
        fw = pend_q.pop_front();
        fq.push_back(fw);
        exp_q.push_back(fw);
      end
      fifo_e <= (fq.size() == 0);
    end
  end

  // ---------------- downstream ready driver ----------------
  bit rdy_rand  = 1'b0;
  bit rdy_const = 1'b1;

  always @(posedge clk) begin
    #1;
    m_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_const;
  end

  // ---------------- reference model and monitor ----------------
  int  cyc = 0;
  bit  mdl_busy = 1'b0;
  int  mdl_len = 0;
  int  mdl_deliv = 0;
  bit  exp_done = 1'b0;
  int  outst = 0;
  int  b_start_cyc, b_first_re, b_first_val, b_first_pop, b_last_pop;
  int  b_reads, b_pops, b_run, b_maxrun, b_reads_at_pop, b_done_cnt;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic [7:0] expw;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mdl_busy   = 1'b0;
      exp_done   = 1'b0;
      outst      = 0;
      prev_stall = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(mdl_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (done === 1'b1) b_done_cnt++;
      chk("re_while_empty", 32'(fifo_re && fifo_e), 32'd0);
      if (!mdl_busy) chk("valid_when_idle", 32'(m_valid), 32'd0);
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
        chk("hold_last", 32'(m_last), 32'(prev_last));
      end
      exp_done = 1'b0;
      if (start && !mdl_busy) begin
        mdl_busy    = 1'b1;
        mdl_len     = (len == 8'd0) ? 256 : int'(len);
        mdl_deliv   = 0;
        b_start_cyc = cyc;
        b_first_re  = -1;
        b_first_val = -1;
        b_first_pop = -1;
        b_last_pop  = -1;
        b_reads     = 0;
        b_pops      = 0;
        b_run       = 0;
        b_maxrun    = 0;
        b_reads_at_pop = -1;
        b_done_cnt  = 0;
      end
      if (fifo_re) begin
        if (b_first_re < 0) b_first_re = cyc;
        b_run++;
        if (b_run > b_maxrun) b_maxrun = b_run;
      end else begin
        b_run = 0;
      end
      if (m_valid && b_first_val < 0) b_first_val = cyc;
      if (m_valid && m_ready && mdl_busy) begin
        if (b_pops == 0) begin
          b_reads_at_pop = b_reads;
          b_first_pop    = cyc;
        end
        b_last_pop = cyc;
        chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          expw = exp_q.pop_front();
          chk("data", 32'(m_data), 32'(expw));
        end
        chk("last", 32'(m_last), 32'(mdl_deliv == mdl_len - 1));
        mdl_deliv++;
        b_pops++;
        outst--;
        if (mdl_deliv == mdl_len) begin
          mdl_busy = 1'b0;
          exp_done = 1'b1;
        end
      end
      if (fifo_re) begin
        b_reads++;
        outst++;
      end
      chk("outstanding_le_2", 32'(outst <= 2), 32'd1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    tick();
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = 8'($urandom);
  endtask

  task automatic push_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) pend_q.push_back(base + 8'(i));
  endtask

  task automatic wait_fill(input int n);
    int k = 0;
    while (fq.size() < n && k < 50) begin
      tick();
      k++;
    end
    chk("fifo_prefill", 32'(fq.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k = 0;
    bit ok = 1'b0;
    while (k < budget && !ok) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
      k++;
    end
    chk({nm, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] len;
    bit         rnd_ready;
    bit         rnd_prod;
    int         exp_words;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{8'd1,   1'b0, 1'b0, 1};
    vecs[1] = '{8'd2,   1'b1, 1'b1, 2};
    vecs[2] = '{8'd7,   1'b1, 1'b0, 7};
    vecs[3] = '{8'd0,   1'b1, 1'b1, 256};
    vecs[4] = '{8'd255, 1'b0, 1'b1, 255};
    vecs[5] = '{8'd9,   1'b1, 1'b1, 9};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_fifo_re", 32'(fifo_re), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;

    // Prefilled 1..5, len 5, always ready
    rdy_rand = 1'b0; rdy_const = 1'b1; prod_rand = 1'b0;
    push_words(8'd1, 5);
    wait_fill(5);
    do_start(8'd5);
    wait_done(100, "t1");
    settle();
    chk("t1_pops", 32'(b_pops), 32'd5);
    chk("t1_reads", 32'(b_reads), 32'd5);
    chk("t1_re_run", 32'(b_maxrun), 32'd5);
    chk("t1_first_re_lat", 32'(b_first_re - b_start_cyc), 32'd1);
    chk("t1_re_to_valid", 32'(b_first_val - b_first_re), 32'd2);
    chk("t1_pop_span", 32'(b_last_pop - b_first_pop), 32'd4);
    chk("t1_done_cnt", 32'(b_done_cnt), 32'd1);

    // Backpressure: 8 words, ready low for 6 cycles
    rdy_const = 1'b0;
    push_words(8'd1, 8);
    wait_fill(8);
    do_start(8'd8);
    repeat (3) tick();
    @(negedge clk);
    chk("t2_held_valid", 32'(m_valid), 32'd1);
    chk("t2_held_data", 32'(m_data), 32'd1);
    repeat (3) tick();
    rdy_const = 1'b1;
    wait_done(200, "t2");
    settle();
    chk("t2_reads_before_pop", 32'(b_reads_at_pop), 32'd2);
    chk("t2_pops", 32'(b_pops), 32'd8);
    chk("t2_reads", 32'(b_reads), 32'd8);

    // Underflow: start on an empty FIFO, words trickle in
    chk("t3_fifo_empty", 32'(fifo_e), 32'd1);
    do_start(8'd3);
    pend_q.push_back(8'hA0);
    repeat (4) tick();
    pend_q.push_back(8'hA1);
    repeat (4) tick();
    pend_q.push_back(8'hA2);
    wait_done(100, "t3");
    settle();
    chk("t3_pops", 32'(b_pops), 32'd3);
    chk("t3_done_cnt", 32'(b_done_cnt), 32'd1);

    // Table-driven bursts
    for (int v = 0; v < 6; v++) begin
      rdy_rand  = vecs[v].rnd_ready;
      prod_rand = vecs[v].rnd_prod;
      rdy_const = 1'b1;
      push_words(8'(16 * v), vecs[v].exp_words);
      do_start(vecs[v].len);
      wait_done(3000, "vec");
      settle();
      chk("vec_pops", 32'(b_pops), 32'(vecs[v].exp_words));
      chk("vec_reads", 32'(b_reads), 32'(vecs[v].exp_words));
      chk("vec_done_cnt", 32'(b_done_cnt), 32'd1);
      chk("vec_fifo_drained", 32'(fq.size()), 32'd0);
    end

    // Start pulsed again mid-burst is ignored
    rdy_rand = 1'b1; prod_rand = 1'b0;
    push_words(8'h40, 6);
    do_start(8'd6);
    repeat (3) tick();
    do_start(8'd2);
    wait_done(300, "t5");
    settle();
    chk("t5_pops", 32'(b_pops), 32'd6);
    chk("t5_done_cnt", 32'(b_done_cnt), 32'd1);
    chk("t5_idle_after", 32'(busy), 32'd0);

    // Reset mid-burst with one word buffered
    rdy_rand = 1'b0; rdy_const = 1'b0;
    push_words(8'h60, 4);
    wait_fill(4);
    do_start(8'd4);
    begin
      int k = 0;
      while (m_valid !== 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("t6_valid_seen", 32'(m_valid), 32'd1);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_rst", 32'(m_valid), 32'd0);
    chk("t6_busy_after_rst", 32'(busy), 32'd0);
    chk("t6_re_after_rst", 32'(fifo_re), 32'd0);
    rdy_const = 1'b1;
    push_words(8'h70, 3);
    do_start(8'd3);
    wait_done(100, "t6");
    settle();
    chk("t6_pops", 32'(b_pops), 32'd3);
    chk("t6_done_cnt", 32'(b_done_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
